// File: rtl/tristate_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg : shared state encoding and counter sizing for tristate_bus_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } arb_state_e;

  // One width serves both the hold and turnaround counters.
  function automatic int cnt_width(input int turn, input int max_hold);
    int m;
    m = (turn > max_hold) ? turn : max_hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tristate_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter_if : request/grant/driver-enable bundle for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tristate_bus_arbiter_if #(
  parameter int N = 4
) ();

  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  en_n;
  logic [OW-1:0] owner;
  logic          busy;

  modport master (
    input  req,
    output gnt,
    output en_n,
    output owner,
    output busy
  );

  modport slave (
    output req,
    input  gnt,
    input  en_n,
    input  owner,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin winner search starting at ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W:0] cand;

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    valid = |req;
    idx   = ptr;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (W + 1)'(off);
      if (cand >= (W + 1)'(N)) begin
        cand = cand - (W + 1)'(N);
      end
      if (req[cand[W-1:0]]) begin
        idx = cand[W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter : round-robin owner sequencing with break-before-make gap
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tristate_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int            OW         = $clog2(N);
  localparam int            CW         = cnt_width(TURN, MAX_HOLD);
  localparam logic [CW-1:0] C_TURN     = CW'(TURN);
  localparam logic [CW-1:0] C_MAX_HOLD = CW'(MAX_HOLD);
  localparam logic [CW-1:0] C_HCNT_SAT = (MAX_HOLD != 0) ? C_MAX_HOLD : {CW{1'b1}};
  localparam logic [N-1:0]  C_ONE      = N'(1);
  localparam logic [OW-1:0] C_LAST     = OW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  en_n_q, en_n_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          owner_req;
  logic          other_req;
  logic          hold_limit;
  logic [OW-1:0] next_ptr;

  rr_pick #(
    .N (N),
    .W (OW)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // gnt_q is one-hot on owner_q while in GRANT, so it masks the owner out.
  assign owner_req  = bus.req[owner_q];
  assign other_req  = |(bus.req & ~gnt_q);
  assign hold_limit = (MAX_HOLD != 0) && (hcnt_q == C_MAX_HOLD) && other_req;
  assign next_ptr   = (owner_q == C_LAST) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    owner_d = owner_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_GRANT;
          owner_d = pick_idx;
          hcnt_d  = CW'(1);
        end
      end

      S_GRANT: begin
        if (!owner_req || hold_limit) begin
          state_d = S_TURN;
          ptr_d   = next_ptr;
          tcnt_d  = C_TURN;
          hcnt_d  = '0;
        end else if (hcnt_q != C_HCNT_SAT) begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end

      S_TURN: begin
        if (tcnt_q <= CW'(1)) begin
          tcnt_d = '0;
          if (pick_valid) begin
            state_d = S_GRANT;
            owner_d = pick_idx;
            hcnt_d  = CW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from next state so they can be registered directly.
    gnt_d  = (state_d == S_GRANT) ? (C_ONE << owner_d) : '0;
    en_n_d = ~gnt_d;
    busy_d = (state_d != S_IDLE);
  end

  // Asynchronous reset releases every driver to high-Z without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      gnt_q   <= '0;
      en_n_q  <= '1;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
      en_n_q  <= en_n_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.en_n  = en_n_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule

`default_nettype wire
